mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port: round-robin, with optional lock bursts capped at MAX_BURST.
// Latency: grant is combinational with req; read data and rd_valid arrive one cycle after the granted read.
// Backpressure: a requester holds req until it sees gnt; a locked owner yields after MAX_BURST grants if the other waits.
//
// Ports: clk, rst (async, active-low); per requester x in {a,b}: x_req, x_lock, x_addr, x_wr_data,
//   x_wr_ena, x_access in; x_gnt, x_rd_data, x_rd_valid out. Shared memory side: mem_addr, mem_wr_data,
//   mem_wr_ena, mem_access out; mem_rd_data in. Status: owner (0 = A, 1 = B), locked.
// Optional: define MEM_ARB_PERF_COUNTERS_EN to add 32-bit a_grant_count / b_grant_count outputs.
module mem_port_arbiter #(
    parameter int  W            = 32,
    parameter int  MAX_BURST    = 8,
    parameter type mem_access_t = logic [1:0]
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_req,
    input  logic         a_lock,
    input  logic [W-1:0] a_addr,
    input  logic [W-1:0] a_wr_data,
    input  logic         a_wr_ena,
    input  mem_access_t  a_access,
    input  logic         b_req,
    input  logic         b_lock,
    input  logic [W-1:0] b_addr,
    input  logic [W-1:0] b_wr_data,
    input  logic         b_wr_ena,
    input  mem_access_t  b_access,
    output logic         a_gnt,
    output logic [W-1:0] a_rd_data,
    output logic         a_rd_valid,
    output logic         b_gnt,
    output logic [W-1:0] b_rd_data,
    output logic         b_rd_valid,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wr_data,
    output logic         mem_wr_ena,
    output mem_access_t  mem_access,
    input  logic [W-1:0] mem_rd_data,
    output logic         owner,
    output logic         locked
`ifdef MEM_ARB_PERF_COUNTERS_EN
    ,
    output logic [31:0]  a_grant_count,
    output logic [31:0]  b_grant_count
`endif
);

    localparam int CW = ($clog2(MAX_BURST + 1) > 4) ? $clog2(MAX_BURST + 1) : 4;
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          owner_nxt;
    logic [CW-1:0] burst_cnt;
    logic [CW-1:0] burst_nxt;
    logic [CW-1:0] burst_inc;
    logic          grant_a;
    logic          grant_b;
    logic          grant_lock;
    logic          other_req;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            owner     <= 1'b1;      // so A wins the first tie
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Grant selection and next-state
    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_nxt  = state;
        owner_nxt  = owner;
        burst_nxt  = burst_cnt;
        burst_inc  = '0;
        grant_lock = 1'b0;
        other_req  = 1'b0;

        // Grants are combinational, so reset must gate them directly.
        if (rst) begin
            if (state == S_LOCKED) begin
                grant_a = a_req && !owner;
                grant_b = b_req && owner;
            end else if (a_req && b_req) begin
                // Tie goes to whoever was not granted last.
                grant_a = owner;
                grant_b = !owner;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end

        grant_lock = grant_b ? b_lock : a_lock;
        other_req  = grant_b ? a_req : b_req;

        // The entry grant counts as the first of the burst; saturate so an
        // uncontended owner can stay locked indefinitely.
        if (state == S_IDLE)
            burst_inc = CW'(1);
        else if (burst_cnt >= BURST_MAX)
            burst_inc = BURST_MAX;
        else
            burst_inc = burst_cnt + CW'(1);

        if (grant_a || grant_b) begin
            owner_nxt = grant_b;
            // Release on the grant that reaches the cap, so the waiting
            // requester wins the very next cycle without a bubble.
            if (grant_lock && !((burst_inc >= BURST_MAX) && other_req)) begin
                state_nxt = S_LOCKED;
                burst_nxt = burst_inc;
            end else begin
                state_nxt = S_IDLE;
                burst_nxt = '0;
            end
        end else if (state == S_LOCKED) begin
            // Locked owner dropped req.
            state_nxt = S_IDLE;
            burst_nxt = '0;
        end
    end

    assign a_gnt  = grant_a;
    assign b_gnt  = grant_b;
    assign locked = (state == S_LOCKED);

    // Shared memory port: follow the granted requester, otherwise the owner,
    // but never issue a write without a grant.
    always_comb begin
        mem_addr    = a_addr;
        mem_wr_data = a_wr_data;
        mem_access  = a_access;
        mem_wr_ena  = (grant_a && a_wr_ena) || (grant_b && b_wr_ena);
        if (grant_b || (!grant_a && owner)) begin
            mem_addr    = b_addr;
            mem_wr_data = b_wr_data;
            mem_access  = b_access;
        end
    end

    // Read return path: capture on the granted read, pulse valid next cycle,
    // hold data until that requester's next granted read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_rd_valid <= 1'b0;
            b_rd_valid <= 1'b0;
            a_rd_data  <= '0;
            b_rd_data  <= '0;
        end else begin
            a_rd_valid <= grant_a && !a_wr_ena;
            b_rd_valid <= grant_b && !b_wr_ena;
            if (grant_a && !a_wr_ena)
                a_rd_data <= mem_rd_data;
            if (grant_b && !b_wr_ena)
                b_rd_data <= mem_rd_data;
        end
    end

`ifdef MEM_ARB_PERF_COUNTERS_EN
    // Free-running grant counters, wrap at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_grant_count <= '0;
            b_grant_count <= '0;
        end else begin
            if (grant_a)
                a_grant_count <= a_grant_count + 32'd1;
            if (grant_b)
                b_grant_count <= b_grant_count + 32'd1;
        end
    end
`endif

endmodule
